// File: rtl/i2c_emit.sv
// rtl/i2c_emit.sv - open-drain I2C master byte engine (START/RS/STOP, one byte per command)
module i2c_emit #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_start,
   input  logic       cmd_stop,
   input  logic       cmd_read,
   input  logic       cmd_nack,
   input  logic [7:0] cmd_data,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [8:0] rsp_word,
   output logic       rsp_valid,
   output logic       arb_lost,
   output logic       bus_held
);

   typedef enum logic [3:0] {
      S_IDLE, S_START_A, S_START_B, S_START_C, S_RS_A, S_RS_B,
      S_BIT, S_HOLD, S_STOP_A, S_STOP_B, S_STOP_C
   } state_t;

   localparam logic [15:0] LP_LAST = 16'(CLK_DIV - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [1:0]  r_phase;
   logic [3:0]  r_bit;
   logic        r_stop;
   logic        r_read;
   logic        r_nack;
   logic [7:0]  r_data;
   logic [7:0]  r_shift;
   logic        r_bus_held;
   logic [8:0]  r_rsp_word;
   logic        r_rsp_valid;
   logic        r_arb_lost;

   logic        w_freeze;
   logic        w_tick;
   logic        w_is_ack;
   logic        w_data_bit;
   logic        w_q3_end;
   logic        w_arb;
   logic        w_need_start;
   logic [7:0]  w_sample;
   logic [7:0]  w_arb_data;

   assign w_is_ack     = (r_bit == 4'd8);
   assign w_data_bit   = r_data[3'd7 - r_bit[2:0]];
   // SCL released but still low means a target is stretching: stop the quarter count
   assign w_freeze     = ~scl_in & (((r_state == S_BIT) & (r_phase == 2'd2)) |
                                    (r_state == S_RS_B) | (r_state == S_STOP_B));
   assign w_tick       = ~w_freeze & (r_cnt == LP_LAST);
   assign w_q3_end     = (r_state == S_BIT) & (r_phase == 2'd3) & w_tick;
   assign w_sample     = {r_shift[6:0], sda_in};
   assign w_arb        = w_q3_end & ~r_read & ~w_is_ack & w_data_bit & ~sda_in;
   assign w_arb_data   = w_sample << (3'd7 - r_bit[2:0]);
   assign w_need_start = cmd_start | ~r_bus_held;

   assign cmd_ready = (r_state == S_IDLE);
   assign rsp_word  = r_rsp_word;
   assign rsp_valid = r_rsp_valid;
   assign arb_lost  = r_arb_lost;
   assign bus_held  = r_bus_held;

   // state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state and pad drive decode
   always_comb begin
      w_state_nxt = r_state;
      scl_oe      = 1'b0;
      sda_oe      = 1'b0;
      case (r_state)
         S_IDLE: begin
            scl_oe = r_bus_held;
            if (cmd_valid)
               w_state_nxt = ~w_need_start ? S_BIT : (r_bus_held ? S_RS_A : S_START_A);
         end
         S_START_A: if (w_tick) w_state_nxt = S_START_B;
         S_START_B: begin
            sda_oe = 1'b1;
            if (w_tick) w_state_nxt = S_START_C;
         end
         S_START_C: begin
            scl_oe = 1'b1;
            sda_oe = 1'b1;
            if (w_tick) w_state_nxt = S_BIT;
         end
         S_RS_A: begin
            scl_oe = 1'b1;
            if (w_tick) w_state_nxt = S_RS_B;
         end
         S_RS_B: if (w_tick) w_state_nxt = S_START_B;
         S_BIT: begin
            scl_oe = ~r_phase[1];
            sda_oe = w_is_ack ? (r_read & ~r_nack) : (~r_read & ~w_data_bit);
            if (w_arb)                    w_state_nxt = S_IDLE;
            else if (w_q3_end & w_is_ack) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            scl_oe = 1'b1;
            sda_oe = r_read & ~r_nack;
            if (w_tick) w_state_nxt = r_stop ? S_STOP_A : S_IDLE;
         end
         S_STOP_A: begin
            scl_oe = 1'b1;
            sda_oe = 1'b1;
            if (w_tick) w_state_nxt = S_STOP_B;
         end
         S_STOP_B: begin
            sda_oe = 1'b1;
            if (w_tick) w_state_nxt = S_STOP_C;
         end
         S_STOP_C: if (w_tick) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // quarter-period counter, restarted on every state change
   always_ff @(posedge clk) begin
      if (reset)                                        r_cnt <= '0;
      else if ((w_state_nxt != r_state) || (r_state == S_IDLE)) r_cnt <= '0;
      else if (w_freeze)                                r_cnt <= r_cnt;
      else if (w_tick)                                  r_cnt <= '0;
      else                                              r_cnt <= r_cnt + 16'd1;
   end

   // quarter phase and bit index inside the byte
   always_ff @(posedge clk) begin
      if (reset || (r_state != S_BIT)) begin
         r_phase <= '0;
         r_bit   <= '0;
      end else if (w_tick) begin
         r_phase <= r_phase + 2'd1;
         if (r_phase == 2'd3) r_bit <= r_bit + 4'd1;
      end
   end

   // command capture at acceptance and receive shift register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stop  <= 1'b0;
         r_read  <= 1'b0;
         r_nack  <= 1'b0;
         r_data  <= '0;
         r_shift <= '0;
      end else if (cmd_valid && cmd_ready) begin
         r_stop  <= cmd_stop;
         r_read  <= cmd_read;
         r_nack  <= cmd_nack;
         r_data  <= cmd_data;
         r_shift <= '0;
      end else if (w_q3_end && !w_is_ack) begin
         r_shift <= w_sample;
      end
   end

   // bus ownership between our START and STOP (lost on arbitration)
   always_ff @(posedge clk) begin
      if (reset)                               r_bus_held <= 1'b0;
      else if (w_arb)                          r_bus_held <= 1'b0;
      else if ((r_state == S_START_C) && w_tick) r_bus_held <= 1'b1;
      else if ((r_state == S_STOP_C) && w_tick)  r_bus_held <= 1'b0;
   end

   // response word and its one-cycle strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rsp_word  <= '0;
         r_rsp_valid <= 1'b0;
         r_arb_lost  <= 1'b0;
      end else begin
         r_rsp_valid <= 1'b0;
         r_arb_lost  <= 1'b0;
         if (w_arb) begin
            r_rsp_word  <= {w_arb_data, 1'b1};
            r_rsp_valid <= 1'b1;
            r_arb_lost  <= 1'b1;
         end else if (w_q3_end && w_is_ack) begin
            r_rsp_word  <= {r_shift, sda_in};
            r_rsp_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_emit.sv
// tb/tb_i2c_emit.sv - randomized bench for i2c_emit with a bus-level target model
module tb_i2c_emit;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_start = 1'b0;
   logic       cmd_stop = 1'b0;
   logic       cmd_read = 1'b0;
   logic       cmd_nack = 1'b0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_ready;
   logic       scl_in;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic [8:0] rsp_word;
   logic       rsp_valid;
   logic       arb_lost;
   logic       bus_held;

   i2c_emit #(.CLK_DIV(D)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_read(cmd_read),
      .cmd_nack(cmd_nack), .cmd_data(cmd_data),
      .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
      .rsp_word(rsp_word), .rsp_valid(rsp_valid), .arb_lost(arb_lost),
      .bus_held(bus_held)
   );

   always #5 clk = ~clk;

   // target model state (main thread owns the tgt_* setup, monitor owns bus tracking)
   logic       tgt_en = 1'b0;
   logic       tgt_arm = 1'b0;
   int         arm_mark = 0;
   logic       tgt_read = 1'b0;
   logic       tgt_nack = 1'b0;
   logic [7:0] tgt_byte = 8'h00;
   int         tgt_arb = -1;
   logic       st_req = 1'b0;

   int         idx = -1;
   logic       in_xfer = 1'b0;
   int         n_start = 0;
   int         n_stop = 0;
   logic       stretch = 1'b0;
   int         st_cnt = 0;
   logic       st_fired = 1'b0;
   logic       p_scl = 1'b1;
   logic       p_sda = 1'b1;
   logic       p_scl_oe = 1'b0;
   logic       m_scl;
   logic       m_sda;
   logic       tgt_low;
   logic [7:0] tgt_sh;

   always_comb begin
      tgt_sh  = tgt_byte << idx;
      tgt_low = 1'b0;
      if ((tgt_en || (tgt_arm && (n_start != arm_mark))) && idx >= 0) begin
         if (idx == 8)      tgt_low = !tgt_read && !tgt_nack;
         else if (tgt_read) tgt_low = !tgt_sh[7];
         else               tgt_low = (idx == tgt_arb);
      end
   end

   assign scl_in = ~(scl_oe | stretch);
   assign sda_in = ~(sda_oe | tgt_low);

   always @(negedge clk) begin
      m_scl = scl_in;
      m_sda = sda_in;
      if (p_scl && m_scl && p_sda && !m_sda) begin
         in_xfer = 1'b1;
         idx = -1;
         n_start++;
      end else if (p_scl && m_scl && !p_sda && m_sda) begin
         in_xfer = 1'b0;
         n_stop++;
      end
      if (!p_scl_oe && scl_oe && in_xfer) idx = (idx + 1) % 9;
      if (!st_req) st_fired = 1'b0;
      if (stretch) begin
         st_cnt--;
         if (st_cnt == 0) stretch = 1'b0;
      end else if (st_req && !st_fired && in_xfer && idx == 3 && p_scl_oe && !scl_oe) begin
         stretch  = 1'b1;
         st_cnt   = 50;
         st_fired = 1'b1;
      end
      p_scl    = m_scl;
      p_sda    = m_sda;
      p_scl_oe = scl_oe;
   end

   int   n_chk = 0;
   int   n_pass = 0;
   logic m_held = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic run_cmd(input logic st, input logic sp, input logic rd, input logic nk,
                          input logic [7:0] data, input int arb, input logic tnack,
                          input logic strch, input logic poke);
      logic       do_start;
      int         start_q;
      logic       arb_hit;
      logic [7:0] bus;
      logic [7:0] keep;
      logic [8:0] exp_w;
      int         exp_lat;
      int         cyc;
      int         pulses;
      logic [8:0] got_w;
      logic       got_arb;
      logic       got_held;
      do_start = st || !m_held;
      start_q  = !do_start ? 0 : (m_held ? 4 : 3);
      arb_hit  = 1'b0;
      bus      = data;
      if (!rd && arb >= 0) begin
         bus     = data & ~(8'h80 >> arb);
         arb_hit = data[7-arb];
      end
      if (rd)           exp_w = {data, nk};
      else if (arb_hit) begin
         keep  = 8'hFF << (7 - arb);
         exp_w = {bus & keep, 1'b1};
      end else          exp_w = {bus, tnack};
      exp_lat = arb_hit ? (start_q + 4*arb + 4) * D : (start_q + 36) * D + (strch ? 50 : 0);

      tgt_read = rd;
      tgt_byte = data;
      tgt_nack = tnack;
      tgt_arb  = rd ? -1 : arb;
      if (do_start) begin
         arm_mark = n_start;
         tgt_arm  = 1'b1;
      end else tgt_en = 1'b1;
      st_req = strch;

      check_eq("ready_before", cmd_ready, 1);
      cmd_start = st; cmd_stop = sp; cmd_read = rd; cmd_nack = nk; cmd_data = data;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc = 0; pulses = 0; got_w = '0; got_arb = 1'b0; got_held = 1'b0;
      while (cyc < 2000 && pulses == 0) begin
         @(negedge clk);
         cyc++;
         if (poke && cyc == 6) cmd_valid = 1'b0;
         if (poke && cyc == 5) begin
            cmd_valid = 1'b1;
            cmd_data  = ~data;
         end
         if (rsp_valid) begin
            pulses++;
            got_w    = rsp_word;
            got_arb  = arb_lost;
            got_held = bus_held;
         end
      end
      cmd_valid = 1'b0;
      tgt_en = 1'b0; tgt_arm = 1'b0; st_req = 1'b0;
      check_eq("rsp_word", got_w, exp_w);
      check_eq("arb_lost", got_arb, arb_hit);
      check_eq("latency", cyc, exp_lat);
      check_eq("held_at_rsp", got_held, !arb_hit);
      if (arb_hit) begin
         check_eq("arb_scl_oe", scl_oe, 0);
         check_eq("arb_sda_oe", sda_oe, 0);
         check_eq("arb_ready", cmd_ready, 1);
      end
      m_held = arb_hit ? 1'b0 : !sp;
      cyc = 0;
      while (!cmd_ready && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) pulses++;
      end
      check_eq("rsp_pulses", pulses, 1);
      check_eq("held_idle", bus_held, m_held);
      check_eq("scl_idle", scl_oe, m_held);
      if (!m_held) check_eq("sda_idle", sda_oe, 0);
   endtask

   initial begin
      int s0;
      int n0;
      logic       rd;
      logic [7:0] dat;
      int         arb;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_eq("rst_scl_oe", scl_oe, 0);
      check_eq("rst_sda_oe", sda_oe, 0);
      check_eq("rst_ready", cmd_ready, 1);
      check_eq("rst_rsp_word", rsp_word, 0);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_arb_lost", arb_lost, 0);
      check_eq("rst_bus_held", bus_held, 0);
      @(negedge clk);

      run_cmd(1, 1, 0, 0, 8'hA5, -1, 0, 0, 0);
      check_eq("stop_count_a5", n_stop, 1);

      s0 = n_stop; n0 = n_start;
      run_cmd(1, 0, 1, 1, 8'h3C, -1, 0, 0, 0);
      check_eq("no_stop_after_read", n_stop, s0);
      run_cmd(1, 1, 0, 0, 8'h55, -1, 0, 0, 0);
      check_eq("rs_start_count", n_start - n0, 2);

      run_cmd(1, 1, 0, 0, 8'h96, -1, 0, 1, 0);
      run_cmd(1, 1, 0, 0, 8'hFF, 1, 0, 0, 0);

      tgt_read = 1'b0; tgt_byte = 8'hC3; tgt_nack = 1'b0; tgt_arb = -1;
      arm_mark = n_start; tgt_arm = 1'b1;
      cmd_start = 1'b1; cmd_stop = 1'b1; cmd_read = 1'b0; cmd_data = 8'hC3;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat ((3 + 5*4 + 2) * D) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_scl_oe", scl_oe, 0);
      check_eq("midrst_sda_oe", sda_oe, 0);
      check_eq("midrst_held", bus_held, 0);
      check_eq("midrst_ready", cmd_ready, 1);
      reset = 1'b0; tgt_arm = 1'b0; m_held = 1'b0;
      repeat (2) @(negedge clk);
      run_cmd(1, 1, 0, 0, 8'h5A, -1, 0, 0, 1);

      for (int i = 0; i < 40; i++) begin
         rd  = 1'($urandom % 2);
         dat = 8'($urandom);
         arb = (!rd && ($urandom % 4 == 0)) ? int'($urandom % 8) : -1;
         run_cmd(1'($urandom % 2), 1'($urandom % 3 == 0), rd, 1'($urandom % 2), dat, arb,
                 1'($urandom % 2), (arb < 0) && ($urandom % 4 == 0), 1'($urandom % 4 == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
